inst_fetch_unit: RTL and testbench

- CPU-side initiator of the instruction fetch interface. Issues sequential fetch requests (fetch_pc, fetch_id) to instruction memory and accepts in-order responses on the inst_* channel.
- Checks response IDs, buffers accepted instructions in a small FIFO, and presents them to decode on a valid/ready channel.
- Stops at the instruction flagged inst_last, then discards any speculative responses already in flight.

---
 rtl/inst_fetch_unit_if.sv | 58 +++++
 rtl/inst_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Instruction fetch bus: request channel to memory, response channel back, and
// the buffered instruction channel toward decode.
interface inst_fetch_unit_if #(
    parameter int PC_BIT      = 8,
    parameter int INST_ID_BIT = 8,
    parameter int OP_BIT      = 3,
    parameter int REG_ID_BIT  = 3,
    parameter int IMM_BIT     = 4
);
    // Every channel is valid/ready: a transfer happens on the rising clock edge
    // where both are high; once raised, valid and its payload hold until taken.
    logic                   fetch_vld;
    logic                   fetch_rdy;
    logic [PC_BIT-1:0]      fetch_pc;
    logic [INST_ID_BIT-1:0] fetch_id;

    logic                   inst_vld;
    logic                   inst_rdy;
    logic [INST_ID_BIT-1:0] inst_id;
    logic                   inst_last;
    logic [OP_BIT-1:0]      inst_op;
    logic [REG_ID_BIT-1:0]  inst_dst_reg;
    logic [REG_ID_BIT-1:0]  inst_src_reg0;
    logic [REG_ID_BIT-1:0]  inst_src_reg1;
    logic [IMM_BIT-1:0]     inst_imm;

    logic                   dec_vld;
    logic                   dec_rdy;
    logic [INST_ID_BIT-1:0] dec_id;
    logic                   dec_last;
    logic [OP_BIT-1:0]      dec_op;
    logic [REG_ID_BIT-1:0]  dec_dst_reg;
    logic [REG_ID_BIT-1:0]  dec_src_reg0;
    logic [REG_ID_BIT-1:0]  dec_src_reg1;
    logic [IMM_BIT-1:0]     dec_imm;

    modport master (
        output fetch_vld, fetch_pc, fetch_id,
        input  fetch_rdy,
        input  inst_vld, inst_id, inst_last, inst_op, inst_dst_reg,
               inst_src_reg0, inst_src_reg1, inst_imm,
        output inst_rdy,
        output dec_vld, dec_id, dec_last, dec_op, dec_dst_reg,
               dec_src_reg0, dec_src_reg1, dec_imm,
        input  dec_rdy
    );

    modport slave (
        input  fetch_vld, fetch_pc, fetch_id,
        output fetch_rdy,
        output inst_vld, inst_id, inst_last, inst_op, inst_dst_reg,
               inst_src_reg0, inst_src_reg1, inst_imm,
        input  inst_rdy,
        input  dec_vld, dec_id, dec_last, dec_op, dec_dst_reg,
               dec_src_reg0, dec_src_reg1, dec_imm,
        output dec_rdy
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetcher with tag check and credit-limited FIFO toward decode.
// Optional FETCH_STALL_CNT_EN adds a saturating count of stalled fetch cycles.
module inst_fetch_unit #(
    parameter int PC_BIT      = 8,
    parameter int INST_ID_BIT = 8,
    parameter int OP_BIT      = 3,
    parameter int REG_ID_BIT  = 3,
    parameter int IMM_BIT     = 4,
    parameter int BUF_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PC_BIT-1:0] start_pc,
    inst_fetch_unit_if.master bus,
    output logic              fetch_done,
    output logic              id_err,
    output logic [1:0]        state_dbg
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = INST_ID_BIT + 1 + OP_BIT + 3 * REG_ID_BIT + IMM_BIT;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t                 state, state_nxt;
    logic [PC_BIT-1:0]      next_pc;
    logic [INST_ID_BIT-1:0] next_id, exp_id;
    logic [CNT_W-1:0]       outstanding, fifo_count;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [ENT_W-1:0]       fifo_mem [BUF_DEPTH];
    logic [CNT_W:0]         credit_used;
    logic                   fetch_vld_c, inst_rdy_c;
    logic                   start_hs, fetch_hs, resp_hs, push, pop;

    // Credits cover both buffered and in-flight instructions, so a response always has a slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign start_hs    = (state == IDLE) && start;
    assign fetch_hs    = fetch_vld_c && bus.fetch_rdy;
    assign resp_hs     = bus.inst_vld && inst_rdy_c;
    assign push        = resp_hs && (state == RUN);
    assign pop         = bus.dec_vld && bus.dec_rdy;
    assign state_dbg   = state;

    assign bus.fetch_vld = fetch_vld_c;
    assign bus.fetch_pc  = next_pc;
    assign bus.fetch_id  = next_id;
    assign bus.inst_rdy  = inst_rdy_c;
    assign bus.dec_vld   = (fifo_count != '0);
    assign {bus.dec_id, bus.dec_last, bus.dec_op, bus.dec_dst_reg,
            bus.dec_src_reg0, bus.dec_src_reg1, bus.dec_imm} = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (resp_hs && bus.inst_last) state_nxt = DRAIN;
            DRAIN:   if (outstanding == '0 && fifo_count == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fetch_vld_c = 1'b0;
        inst_rdy_c  = 1'b0;
        fetch_done  = 1'b0;
        unique case (state)
            RUN: begin
                fetch_vld_c = (credit_used < DEPTH_C);
                inst_rdy_c  = 1'b1;
            end
            DRAIN:   inst_rdy_c = 1'b1;
            DONE:    fetch_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_pc     <= '0;
            next_id     <= '0;
            exp_id      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            id_err      <= 1'b0;
        end else if (start_hs) begin
            next_pc     <= start_pc;
            next_id     <= '0;
            exp_id      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            id_err      <= 1'b0;
        end else begin
            if (fetch_hs) begin
                next_pc <= next_pc + PC_BIT'(1);
                next_id <= next_id + INST_ID_BIT'(1);
            end
            case ({fetch_hs, resp_hs})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase
            // Discarded speculative responses still advance the expected tag.
            if (resp_hs) begin
                exp_id <= exp_id + INST_ID_BIT'(1);
                if (bus.inst_id != exp_id) id_err <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.inst_id, bus.inst_last, bus.inst_op, bus.inst_dst_reg,
                                 bus.inst_src_reg0, bus.inst_src_reg1, bus.inst_imm};
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                               stall_cnt <= '0;
        else if (start_hs)                                        stall_cnt <= '0;
        else if (fetch_vld_c && !bus.fetch_rdy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: table of program runs against a 1-cycle
// memory responder, plus hand sequences for reset-state and mid-run async reset.
module tb_inst_fetch_unit;
    localparam int W      = 25;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE = 3;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] id;
    } req_t;

    typedef struct {
        logic [7:0] start_pc;
        int         len;
        int         dec_stall;
        int         corrupt;
        bit         rdy_toggle;
        bit         mid_start;
        bit         exp_discard;
        bit         exp_full;
    } case_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_pc = 8'h00;
    logic       fetch_done, id_err;
    logic [1:0] state_dbg;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    inst_fetch_unit_if bus ();

    inst_fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_pc  (start_pc),
        .bus       (bus),
        .fetch_done(fetch_done),
        .id_err    (id_err),
        .state_dbg (state_dbg)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         ph = P_IDLE;
    logic [7:0] m_pc, m_id, m_eid, last_pc;
    int         m_fifo, resp_idx, fetches, done_cnt, max_occ, cyc;
    bit         m_err;
    int         dec_stall, corrupt;
    bit         rdy_toggle, resp_hold;
    req_t       req_q[$];
    logic [W-1:0] exp_q[$];
    case_t      cases[5];

    function automatic logic [15:0] fields(input logic [7:0] pc);
        return {pc[2:0], pc[5:3], pc[7:5], pc[4:2], pc[3:0] ^ 4'hA};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs against the model at settle, then book the handshakes.
    task automatic step();
        logic fhs, rhs, dhs, st, rlast, old_run, drain_ok;
        logic [7:0] fpc_s, fid_s, rid_s;
        logic [W-1:0] dec_s, e;
        req_t r;
        int occ;
        #1;
        occ = m_fifo + req_q.size();
        chk("fetch_vld", bus.fetch_vld, (ph == P_RUN && occ < 4));
        chk("inst_rdy", bus.inst_rdy, (ph == P_RUN || ph == P_DRAIN));
        chk("dec_vld", bus.dec_vld, (m_fifo != 0));
        chk("fetch_done", fetch_done, (ph == P_DONE));
        chk("id_err", id_err, m_err);
        chk("state_dbg", state_dbg, ph[1:0]);
        if (ph == P_RUN && occ > max_occ) max_occ = occ;
        if (fetch_done) done_cnt++;
        fhs   = bus.fetch_vld && bus.fetch_rdy;
        rhs   = bus.inst_vld && bus.inst_rdy;
        dhs   = bus.dec_vld && bus.dec_rdy;
        st    = start;
        fpc_s = bus.fetch_pc;
        fid_s = bus.fetch_id;
        rid_s = bus.inst_id;
        rlast = bus.inst_last;
        dec_s = {bus.dec_id, bus.dec_last, bus.dec_op, bus.dec_dst_reg,
                 bus.dec_src_reg0, bus.dec_src_reg1, bus.dec_imm};
        @(negedge clk);
        old_run  = (ph == P_RUN);
        drain_ok = (req_q.size() == 0 && m_fifo == 0);
        if (ph == P_IDLE) begin
            if (st) begin
                ph = P_RUN; m_pc = start_pc; m_id = 8'h00; m_eid = 8'h00;
                m_fifo = 0; m_err = 1'b0; resp_idx = 0;
            end
        end else if (ph == P_RUN) begin
            if (rhs && rlast) ph = P_DRAIN;
        end else if (ph == P_DRAIN) begin
            if (drain_ok) ph = P_DONE;
        end else begin
            ph = P_IDLE;
        end
        if (rhs) begin
            r = req_q.pop_front();
            if (rid_s != m_eid) m_err = 1'b1;
            m_eid++;
            if (old_run) m_fifo++;
            resp_idx++;
        end
        if (fhs) begin
            chk("fetch_pc", fpc_s, m_pc);
            chk("fetch_id", fid_s, m_id);
            req_q.push_back('{pc: fpc_s, id: fid_s});
            m_pc++;
            m_id++;
            fetches++;
        end
        if (dhs) begin
            m_fifo--;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dec_extra: got %0h expected nothing", dec_s);
            end else begin
                e = exp_q.pop_front();
                if (dec_s !== e) begin
                    errors++;
                    $display("FAIL dec_entry: got %0h expected %0h", dec_s, e);
                end
            end
        end
        cyc++;
        bus.dec_rdy   = (cyc >= dec_stall);
        bus.fetch_rdy = rdy_toggle ? cyc[0] : 1'b1;
        if (!resp_hold && req_q.size() != 0) begin
            bus.inst_vld  = 1'b1;
            bus.inst_id   = (resp_idx == corrupt) ? 8'h07 : req_q[0].id;
            bus.inst_last = (req_q[0].pc == last_pc);
            {bus.inst_op, bus.inst_dst_reg, bus.inst_src_reg0,
             bus.inst_src_reg1, bus.inst_imm} = fields(req_q[0].pc);
        end else begin
            bus.inst_vld = 1'b0;
        end
    endtask

    task automatic run_case(input case_t c);
        logic [7:0] pc;
        bit finished;
        dec_stall = c.dec_stall; corrupt = c.corrupt; rdy_toggle = c.rdy_toggle;
        resp_hold = 1'b0; fetches = 0; done_cnt = 0; max_occ = 0; cyc = 0;
        last_pc = c.start_pc + 8'(c.len - 1);
        for (int i = 0; i < c.len; i++) begin
            pc = c.start_pc + 8'(i);
            exp_q.push_back({(i == c.corrupt) ? 8'h07 : 8'(i), (i == c.len - 1), fields(pc)});
        end
        bus.dec_rdy = (dec_stall == 0);
        bus.fetch_rdy = 1'b1;
        start_pc = c.start_pc;
        start = 1'b1;
        step();
        start = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 300 && !finished; i++) begin
            start = (c.mid_start && i == 2);
            if (start) start_pc = 8'h99;
            step();
            start = 1'b0;
            finished = (done_cnt > 0 && ph == P_IDLE);
        end
        chk("run_finished", finished, 1'b1);
        chk("done_pulses", done_cnt, 1);
        chk("undelivered", exp_q.size(), 0);
        if (c.exp_discard) chk("spec_discarded", (fetches > c.len), 1'b1);
        if (c.exp_full) chk("credit_limit", max_occ, 4);
        exp_q.delete();
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        cases[0] = '{start_pc: 8'h00, len: 6,  dec_stall: 0,  corrupt: -1, rdy_toggle: 0, mid_start: 1, exp_discard: 1, exp_full: 0};
        cases[1] = '{start_pc: 8'h20, len: 10, dec_stall: 20, corrupt: -1, rdy_toggle: 0, mid_start: 0, exp_discard: 0, exp_full: 1};
        cases[2] = '{start_pc: 8'h30, len: 3,  dec_stall: 0,  corrupt: -1, rdy_toggle: 0, mid_start: 0, exp_discard: 1, exp_full: 0};
        cases[3] = '{start_pc: 8'hFE, len: 4,  dec_stall: 0,  corrupt: -1, rdy_toggle: 0, mid_start: 0, exp_discard: 0, exp_full: 0};
        cases[4] = '{start_pc: 8'h10, len: 5,  dec_stall: 0,  corrupt: 1,  rdy_toggle: 1, mid_start: 0, exp_discard: 0, exp_full: 0};

        bus.fetch_rdy = 1'b1; bus.inst_vld = 1'b0; bus.inst_id = 8'h00; bus.inst_last = 1'b0;
        {bus.inst_op, bus.inst_dst_reg, bus.inst_src_reg0, bus.inst_src_reg1, bus.inst_imm} = 16'h0000;
        bus.dec_rdy = 1'b1;
        dec_stall = 0; corrupt = -1; rdy_toggle = 1'b0; resp_hold = 1'b0; cyc = 0;
        m_fifo = 0; m_err = 1'b0; resp_idx = 0; last_pc = 8'h00;

        #12;
        chk("rst_fetch_vld", bus.fetch_vld, 1'b0);
        chk("rst_inst_rdy", bus.inst_rdy, 1'b0);
        chk("rst_dec_vld", bus.dec_vld, 1'b0);
        chk("rst_fetch_done", fetch_done, 1'b0);
        chk("rst_id_err", id_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        for (int k = 0; k < 5; k++) run_case(cases[k]);

        // Async reset with two fetches outstanding and no responses returned.
        resp_hold = 1'b1; dec_stall = 0; corrupt = -1; rdy_toggle = 1'b0; cyc = 0;
        last_pc = 8'h4F; start_pc = 8'h40;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_outstanding", req_q.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fetch_vld", bus.fetch_vld, 1'b0);
        chk("arst_inst_rdy", bus.inst_rdy, 1'b0);
        chk("arst_dec_vld", bus.dec_vld, 1'b0);
        chk("arst_fetch_done", fetch_done, 1'b0);
        chk("arst_id_err", id_err, 1'b0);
        chk("arst_state", state_dbg, 2'd0);
        ph = P_IDLE; m_fifo = 0; m_err = 1'b0;
        req_q.delete();
        exp_q.delete();
        resp_hold = 1'b0;
        bus.inst_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_case('{start_pc: 8'h80, len: 2, dec_stall: 0, corrupt: -1, rdy_toggle: 0,
                   mid_start: 0, exp_discard: 1, exp_full: 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
